// File: rtl/out_port_arbiter.sv
// Per-output-port arbiter: round-robin with bounded burst hold, feeding a
// single-entry registered output stage on a valid/ready link.
module out_port_arbiter #(
  parameter int unsigned NUM_PORTS = 9,
  parameter int unsigned FLIT_W    = 32,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned IDX_W     = $clog2(NUM_PORTS),
  localparam int unsigned CNT_W    = $clog2(BURST_LEN + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS*FLIT_W-1:0]   req_flit,
  output logic [NUM_PORTS-1:0]          req_ready,
  input  logic [NUM_PORTS-1:0]          port_en,
  output logic                          out_valid,
  output logic [FLIT_W-1:0]             out_flit,
  input  logic                          out_ready,
  output logic [IDX_W-1:0]              grant_idx,
  output logic [CNT_W-1:0]              burst_cnt
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [NUM_PORTS-1:0] eff_req;
  logic                 can_load;
  logic                 hold;
  logic                 rr_found;
  logic [IDX_W-1:0]     rr_idx;
  logic [SUM_W-1:0]     cand;
  logic                 any_win;
  logic [IDX_W-1:0]     win_idx;
  logic [FLIT_W-1:0]    win_flit;
  logic [CNT_W-1:0]     next_cnt;
  logic                 ptr_adv;
  logic [IDX_W-1:0]     ptr_next;
  logic [IDX_W-1:0]     rr_ptr;

  // Masked requests, load window and burst-hold qualification.
  always_comb begin
    eff_req  = req_valid & port_en;
    can_load = !out_valid || out_ready;
    hold     = (burst_cnt != '0) && (burst_cnt < CNT_W'(BURST_LEN)) && eff_req[grant_idx];
  end

  // Round-robin scan starting at rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = SUM_W'(rr_ptr) + SUM_W'(i);
      if (cand >= SUM_W'(NUM_PORTS)) begin
        cand = cand - SUM_W'(NUM_PORTS);
      end
      if (!rr_found && eff_req[cand[IDX_W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Winner select and one-hot accept; silent while reset is held.
  always_comb begin
    win_idx   = hold ? grant_idx : rr_idx;
    any_win   = can_load && (hold || rr_found);
    req_ready = '0;
    if (rst && any_win) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  // Next burst count (saturating) and round-robin pointer advance.
  always_comb begin
    win_flit = req_flit[win_idx*FLIT_W +: FLIT_W];
    if ((win_idx == grant_idx) && (burst_cnt != '0)) begin
      next_cnt = (burst_cnt == CNT_W'(BURST_LEN)) ? burst_cnt : burst_cnt + CNT_W'(1);
    end else begin
      next_cnt = CNT_W'(1);
    end
    ptr_adv  = (next_cnt == CNT_W'(BURST_LEN)) || (win_idx != grant_idx);
    ptr_next = (win_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : win_idx + IDX_W'(1);
  end

  // Output stage and arbitration state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
      grant_idx <= '0;
      burst_cnt <= '0;
      rr_ptr    <= '0;
    end else if (can_load) begin
      if (any_win) begin
        out_valid <= 1'b1;
        out_flit  <= win_flit;
        grant_idx <= win_idx;
        burst_cnt <= next_cnt;
        if (ptr_adv) begin
          rr_ptr <= ptr_next;
        end
      end else begin
        out_valid <= 1'b0;
        burst_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_out_port_arbiter.sv
// Bench for out_port_arbiter: directed scenarios plus randomized traffic,
// compared against a behavioural model of the arbitration rules.
module tb_out_port_arbiter;

  localparam int N  = 9;
  localparam int FW = 32;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*FW-1:0]   req_flit;
  logic [N-1:0]      port_en;
  logic              out_ready;

  logic [N-1:0]      rdy_a, rdy_b;
  logic              ov_a, ov_b;
  logic [FW-1:0]     of_a, of_b;
  logic [3:0]        gi_a, gi_b;
  logic [2:0]        bc_a;
  logic [0:0]        bc_b;

  int n_vec = 0;
  int n_err = 0;

  // Model state: index 0 models BURST_LEN=4, index 1 models BURST_LEN=1.
  int          m_bl[2] = '{4, 1};
  bit          m_valid[2];
  logic [FW-1:0] m_flit[2];
  int          m_gidx[2];
  int          m_cnt[2];
  int          m_ptr[2];

  out_port_arbiter #(.NUM_PORTS(N), .FLIT_W(FW), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_flit(req_flit),
    .req_ready(rdy_a), .port_en(port_en), .out_valid(ov_a), .out_flit(of_a),
    .out_ready(out_ready), .grant_idx(gi_a), .burst_cnt(bc_a)
  );

  out_port_arbiter #(.NUM_PORTS(N), .FLIT_W(FW), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_flit(req_flit),
    .req_ready(rdy_b), .port_en(port_en), .out_valid(ov_b), .out_flit(of_b),
    .out_ready(out_ready), .grant_idx(gi_b), .burst_cnt(bc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [FW-1:0] flit_of(int k);
    return req_flit[k*FW +: FW];
  endfunction

  // Winner the rules pick this cycle, or -1 if nothing loads.
  function automatic int m_win(int u);
    logic [N-1:0] eff;
    eff = req_valid & port_en;
    if (m_valid[u] && !out_ready) return -1;
    if (eff == '0) return -1;
    if (m_cnt[u] > 0 && m_cnt[u] < m_bl[u] && eff[m_gidx[u]]) return m_gidx[u];
    for (int i = 0; i < N; i++) begin
      if (eff[(m_ptr[u] + i) % N]) return (m_ptr[u] + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_rdy(int u);
    logic [N-1:0] r;
    int w;
    r = '0;
    w = m_win(u);
    if (rst && w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_valid[u] = 1'b0; m_flit[u] = '0; m_gidx[u] = 0; m_cnt[u] = 0; m_ptr[u] = 0;
    end
  endtask

  // Advance one clock, updating the model with pre-edge inputs.
  task automatic tick();
    int w[2];
    int nc;
    logic [FW-1:0] f[2];
    bit load[2];
    for (int u = 0; u < 2; u++) begin
      w[u]    = m_win(u);
      f[u]    = (w[u] >= 0) ? flit_of(w[u]) : '0;
      load[u] = !m_valid[u] || out_ready;
    end
    @(posedge clk);
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        if (load[u]) begin
          if (w[u] >= 0) begin
            nc = (w[u] == m_gidx[u] && m_cnt[u] > 0) ?
                 ((m_cnt[u] + 1 > m_bl[u]) ? m_bl[u] : m_cnt[u] + 1) : 1;
            if (nc == m_bl[u] || w[u] != m_gidx[u]) m_ptr[u] = (w[u] + 1) % N;
            m_gidx[u] = w[u]; m_cnt[u] = nc; m_valid[u] = 1'b1; m_flit[u] = f[u];
          end else begin
            m_valid[u] = 1'b0; m_cnt[u] = 0;
          end
        end
      end
    end
    #1;
  endtask

  task automatic rand_flits();
    for (int k = 0; k < N; k++) req_flit[k*FW +: FW] = $urandom;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = '1; port_en = '1; out_ready = 1'b1;
    rand_flits();
    model_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (rdy_a !== '0) begin n_err++; $display("FAIL reset_ready got %h exp 0", rdy_a); end
    n_vec++; if (ov_a !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", ov_a); end
    n_vec++; if (of_a !== '0) begin n_err++; $display("FAIL reset_flit got %h exp 0", of_a); end
    n_vec++; if (gi_a !== 4'd0 || bc_a !== 3'd0) begin n_err++; $display("FAIL reset_idx_cnt got %0d/%0d exp 0/0", gi_a, bc_a); end
    req_valid = '0;
    rst = 1'b1;
  endtask

  task automatic test_single();
    logic [FW-1:0] fl[3];
    for (int i = 0; i < 3; i++) fl[i] = $urandom;
    for (int i = 0; i < 3; i++) begin
      req_valid = 9'h010;
      req_flit[4*FW +: FW] = fl[i];
      #1;
      n_vec++; if (rdy_a !== 9'h010) begin n_err++; $display("FAIL single_ready got %h exp 010", rdy_a); end
      tick();
      n_vec++;
      if (ov_a !== 1'b1 || of_a !== fl[i] || gi_a !== 4'd4 || bc_a !== 3'(i + 1)) begin
        n_err++;
        $display("FAIL single_out got v=%b f=%h g=%0d c=%0d exp v=1 f=%h g=4 c=%0d", ov_a, of_a, gi_a, bc_a, fl[i], i + 1);
      end
      @(negedge clk);
    end
    req_valid = '0;
    tick();
    n_vec++; if (ov_a !== 1'b0 || bc_a !== 3'd0) begin n_err++; $display("FAIL single_drain got v=%b c=%0d exp 0/0", ov_a, bc_a); end
    @(negedge clk);
  endtask

  task automatic test_rr_all();
    logic [N-1:0] exp_r;
    logic [FW-1:0] exp_f;
    apply_reset();
    req_valid = '1;
    for (int i = 0; i < 10; i++) begin
      rand_flits();
      #1;
      exp_r = '0; exp_r[i % N] = 1'b1;
      exp_f = flit_of(i % N);
      n_vec++; if (rdy_b !== exp_r) begin n_err++; $display("FAIL rr_ready got %h exp %h", rdy_b, exp_r); end
      tick();
      n_vec++;
      if (gi_b !== 4'(i % N) || bc_b !== 1'b1 || of_b !== exp_f) begin
        n_err++;
        $display("FAIL rr_grant got g=%0d c=%0d f=%h exp g=%0d c=1 f=%h", gi_b, bc_b, of_b, i % N, exp_f);
      end
      n_vec++;
      if ({ov_a, of_a, gi_a, bc_a} !== {m_valid[0], m_flit[0], 4'(m_gidx[0]), 3'(m_cnt[0])}) begin
        n_err++;
        $display("FAIL rr_burst4 got g=%0d c=%0d exp g=%0d c=%0d", gi_a, bc_a, m_gidx[0], m_cnt[0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_burst();
    int eg;
    logic [N-1:0] exp_r;
    apply_reset();
    req_valid = 9'h084;
    for (int i = 0; i < 12; i++) begin
      rand_flits();
      eg = ((i / 4) % 2 == 1) ? 7 : 2;
      exp_r = '0; exp_r[eg] = 1'b1;
      #1;
      n_vec++; if (rdy_a !== exp_r) begin n_err++; $display("FAIL burst_ready got %h exp %h", rdy_a, exp_r); end
      tick();
      n_vec++;
      if (gi_a !== 4'(eg) || bc_a !== 3'(i % 4 + 1)) begin
        n_err++;
        $display("FAIL burst_seq got g=%0d c=%0d exp g=%0d c=%0d", gi_a, bc_a, eg, i % 4 + 1);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] held, exp_f;
    logic [N-1:0] exp_r;
    out_ready = 1'b0;
    held = of_a;
    for (int i = 0; i < 5; i++) begin
      rand_flits();
      #1;
      n_vec++; if (rdy_a !== '0) begin n_err++; $display("FAIL bp_ready got %h exp 0", rdy_a); end
      tick();
      n_vec++; if (ov_a !== 1'b1 || of_a !== held) begin n_err++; $display("FAIL bp_hold got v=%b f=%h exp v=1 f=%h", ov_a, of_a, held); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    exp_r = m_rdy(0);
    exp_f = flit_of(m_win(0));
    n_vec++; if (rdy_a !== exp_r || exp_r == '0) begin n_err++; $display("FAIL bp_release got %h exp %h", rdy_a, exp_r); end
    tick();
    n_vec++; if (of_a !== exp_f) begin n_err++; $display("FAIL bp_load got %h exp %h", of_a, exp_f); end
    @(negedge clk);
  endtask

  task automatic test_port_en();
    apply_reset();
    port_en = 9'h1FE;
    req_valid = 9'h001;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (rdy_a !== '0) begin n_err++; $display("FAIL en_ready got %h exp 0", rdy_a); end
      tick();
      n_vec++; if (ov_a !== 1'b0) begin n_err++; $display("FAIL en_valid got %b exp 0", ov_a); end
      @(negedge clk);
    end
    req_valid = 9'h009;
    #1;
    n_vec++; if (rdy_a !== 9'h008) begin n_err++; $display("FAIL en_ready3 got %h exp 008", rdy_a); end
    tick();
    n_vec++; if (ov_a !== 1'b1 || gi_a !== 4'd3) begin n_err++; $display("FAIL en_grant got v=%b g=%0d exp v=1 g=3", ov_a, gi_a); end
    @(negedge clk);
    port_en = '1;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_valid = 9'h020;
    repeat (2) begin tick(); @(negedge clk); end
    tick();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (ov_a !== 1'b0 || bc_a !== 3'd0 || gi_a !== 4'd0) begin
      n_err++;
      $display("FAIL mid_reset got v=%b c=%0d g=%0d exp 0/0/0", ov_a, bc_a, gi_a);
    end
    @(negedge clk);
    rst = 1'b1;
    req_valid = 9'h022;
    #1;
    n_vec++; if (rdy_a !== 9'h002) begin n_err++; $display("FAIL mid_first_ready got %h exp 002", rdy_a); end
    tick();
    n_vec++; if (gi_a !== 4'd1) begin n_err++; $display("FAIL mid_first_grant got %0d exp 1", gi_a); end
    @(negedge clk);
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      rand_flits();
      if ($urandom_range(0, 2) == 0) begin
        req_valid = 9'($urandom) & (($urandom_range(0, 1) == 1) ? 9'($urandom) : 9'h1FF);
      end
      port_en = '1;
      if ($urandom_range(0, 4) == 0) port_en[$urandom_range(0, 8)] = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_vec++; if (rdy_a !== m_rdy(0)) begin n_err++; $display("FAIL rand_ready4 got %h exp %h", rdy_a, m_rdy(0)); end
      n_vec++; if (rdy_b !== m_rdy(1)) begin n_err++; $display("FAIL rand_ready1 got %h exp %h", rdy_b, m_rdy(1)); end
      tick();
      n_vec++;
      if ({ov_a, of_a, gi_a, bc_a} !== {m_valid[0], m_flit[0], 4'(m_gidx[0]), 3'(m_cnt[0])}) begin
        n_err++;
        $display("FAIL rand_out4 got v=%b f=%h g=%0d c=%0d exp v=%b f=%h g=%0d c=%0d",
                 ov_a, of_a, gi_a, bc_a, m_valid[0], m_flit[0], m_gidx[0], m_cnt[0]);
      end
      n_vec++;
      if ({ov_b, of_b, gi_b, bc_b} !== {m_valid[1], m_flit[1], 4'(m_gidx[1]), 1'(m_cnt[1])}) begin
        n_err++;
        $display("FAIL rand_out1 got v=%b f=%h g=%0d c=%0d exp v=%b f=%h g=%0d c=%0d",
                 ov_b, of_b, gi_b, bc_b, m_valid[1], m_flit[1], m_gidx[1], m_cnt[1]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0;
    req_flit = '0;
    port_en = '1;
    out_ready = 1'b1;
    model_reset();
    test_reset();
    test_single();
    test_rr_all();
    test_burst();
    test_backpressure();
    test_port_en();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
